// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU among NREQ
//            requesters, with a one-entry backpressurable response buffer.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    input  logic [4*NREQ-1:0]    i_req_op,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    output logic [3:0]           o_alu_op,
    input  logic [31:0]          i_alu_data,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [31:0]          o_rsp_data,
    input  logic                 i_rsp_ready
);

    logic [IDW-1:0]  r_ptr;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_data;

    logic            w_any_valid;
    logic [IDW-1:0]  w_gnt;
    logic            w_can_accept;
    logic [NREQ-1:0] w_ready;
    logic            w_fire;
    logic [IDW-1:0]  w_ptr_nxt;

    // Rotating priority search starting at r_ptr; first valid requester wins.
    always_comb begin
        int w_idx;
        w_any_valid = 1'b0;
        w_gnt       = '0;
        w_idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_any_valid && i_req_valid[w_idx]) begin
                w_any_valid = 1'b1;
                w_gnt       = IDW'(w_idx);
            end
        end
    end

    assign w_can_accept = !r_rsp_valid || i_rsp_ready;

    // Ready is masked while reset is asserted so no request is seen as accepted.
    always_comb begin
        w_ready = '0;
        if (w_any_valid && w_can_accept && i_rst_n) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_fire    = |(i_req_valid & w_ready);
    assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        o_alu_a  = '0;
        o_alu_b  = '0;
        o_alu_op = '0;
        if (w_any_valid) begin
            o_alu_a  = i_req_a[32*int'(w_gnt) +: 32];
            o_alu_b  = i_req_b[32*int'(w_gnt) +: 32];
            o_alu_op = i_req_op[4*int'(w_gnt) +: 4];
        end
    end

    // A fire overwrites the buffer even while it is being drained, so no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_fire) begin
                r_ptr       <= w_ptr_nxt;
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_gnt;
                r_rsp_data  <= i_alu_data;
            end else if (i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single combinational `alu` between up to four requesters, such as the execute stage, the branch-target path and a debug/CSR engine. It uses a valid/ready handshake on both sides. It selects one requester per cycle and steers that requester's operands and op code to the ALU. It registers the ALU result, with the requester ID, into a one-entry response buffer that the consumer can backpressure.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `i_clk`  in  1  the single clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_req_valid`  in  NREQ  bit k means requester k presents an operation.
- `o_req_ready`  out  NREQ  at most one bit set; bit k means requester k is accepted this cycle.
- `i_req_a`  in  32*NREQ  operand A; requester k occupies bits [32k+31:32k].
- `i_req_b`  in  32*NREQ  operand B, packed the same way.
- `i_req_op`  in  4*NREQ  ALU op code; requester k occupies bits [4k+3:4k].
- `o_alu_a`  out  32  operand A for the granted requester, driven to the ALU.
- `o_alu_b`  out  32  operand B for the granted requester, driven to the ALU.
- `o_alu_op`  out  4  op code for the granted requester, driven to the ALU.
- `i_alu_data`  in  32  result returned by the ALU.
- `o_rsp_valid`  out  1  the response buffer holds a result.
- `o_rsp_id`  out  IDW  index of the requester that owns the result.
- `o_rsp_data`  out  32  the captured ALU result.
- `i_rsp_ready`  in  1  the consumer takes the response this cycle.

## Operation
- **Slot free.** `can_accept` = `!o_rsp_valid || i_rsp_ready`.
- **Round-robin pointer.** `ptr` is IDW bits wide and resets to 0.
  - Search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first requester with valid set is `gnt`.
- **Grant.** `o_req_ready[gnt]` = `can_accept`; every other ready bit is 0.
  - If no requester is valid, all ready bits are 0.
- **Fire.** A request fires when `i_req_valid[k] && o_req_ready[k]`. On a fire:
  - `ptr` becomes (k+1) mod NREQ.
  - `o_rsp_data` captures `i_alu_data`.
  - `o_rsp_id` captures k.
  - `o_rsp_valid` is set to 1.
- **Drain.** If `i_rsp_ready` is high with no fire, `o_rsp_valid` clears.
  - `o_rsp_data` and `o_rsp_id` hold their last values.
- **Pointer hold.** `ptr` is unchanged in any cycle without a fire.
- **ALU steering.**
  - While any requester is valid, `o_alu_a`, `o_alu_b` and `o_alu_op` carry the fields of `gnt`, even when `can_accept` = 0.
  - While no requester is valid, they are driven to 0.
- **Op codes.** The arbiter passes op codes unchanged:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and
  - 5 slt, 6 sltu
  - 7 sll, 8 srl, 9 sra
  - 10..15 return 0 from the ALU; they are not an arbiter error.
- **Requester obligation.** Once a requester raises valid, it holds valid and its operands stable until it is accepted. The arbiter does not check this.
- **Response stability.** While `o_rsp_valid` = 1 and `i_rsp_ready` = 0, `o_rsp_data` and `o_rsp_id` are stable.

## Timing
- **Reset values.** On `i_rst_n` low, asynchronously and without waiting for a clock edge:
  - `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_data` = 0, `ptr` = 0.
  - `o_req_ready` is all zero, because `i_req_valid` is ignored while in reset.
- **Reset mid-operation.** A result that has not been drained is lost. Requesters must re-issue after reset.
- **Combinational paths.**
  - `o_req_ready` and the `o_alu_*` outputs are combinational from `i_req_valid`, `ptr`, `o_rsp_valid` and `i_rsp_ready`.
  - The ALU path (`o_alu_*` to `i_alu_data`) must close in one cycle.
- **Latency.** A request accepted at edge N appears as `o_rsp_valid` = 1 after edge N.
- **Throughput.** One request per cycle, sustained while `i_rsp_ready` stays high.
- **Simultaneous drain and fire.** When `o_rsp_valid` = 1, `i_rsp_ready` = 1 and a new request fires in the same cycle, the buffer is overwritten with the new result. `o_rsp_valid` stays 1, with no bubble.
- **Backpressure.** While `o_rsp_valid` = 1 and `i_rsp_ready` = 0, no requester is accepted and `ptr` is frozen.
- **Pointer wrap.** A grant to requester NREQ-1 sets `ptr` to 0.

## Test plan
- **Single request.** NREQ=2. Requester 0 issues a=0x5, b=0x3, op=0 with `i_rsp_ready` = 1.
  - One cycle later: `o_rsp_valid` = 1, `o_rsp_data` = 0x8, `o_rsp_id` = 0, `ptr` = 1.
- **Fairness.** Both requesters hold valid continuously with `i_rsp_ready` = 1. Requester 0 issues op=1 (a=0xA, b=0xB); requester 1 issues op=2.
  - `o_rsp_id` sequence is 0,1,0,1.
  - ID 0 results are 0xFFFFFFFF.
- **Backpressure.** `o_rsp_valid` = 1 with `i_rsp_ready` = 0 for 3 cycles while requester 1 is valid.
  - `o_req_ready` = 0, and `o_rsp_data` and `o_rsp_id` are unchanged.
  - Raising `i_rsp_ready` accepts requester 1 in that same cycle, and `o_rsp_valid` stays 1.
- **Skip and wrap.** NREQ=3, `ptr` = 1, only requesters 0 and 2 valid.
  - Grant goes to 2, then `ptr` = 0, then the grant goes to 0 and `ptr` = 1.
- **Signed shift and compare.** Requester 0 issues a=0x80000000, b=4, op=9, and gets 0xF8000000.
  - a=0xFFFFFFFF, b=1 returns 1 for op=5 and 0 for op=6.
- **Reset mid-operation.** Pull `i_rst_n` low between clock edges while `o_rsp_valid` = 1 and `ptr` = 1.
  - `o_rsp_valid`, `o_rsp_id` and `o_rsp_data` go to 0 immediately, without a clock edge, and `ptr` returns to 0.
  - After release, the first grant goes to requester 0.
